// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
package shared_reg_arbiter_pkg;

  // Arbitration state: free round-robin, or owned by a locked requester.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of idx, wrapping at n (never returns a value >= n).
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 1 >= n) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_valid
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned   w_sum;
  logic [IW-1:0] w_cand;

  // Scan NREQ candidates starting at ptr; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = 0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = 32'(i_ptr) + k;
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_cand = IW'(w_sum);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Owns one shared register; arbitrates load and round-robin/locked requester writes.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         ReqValid,
  input  logic [NREQ-1:0]         ReqLock,
  input  logic [NREQ*WIDTH-1:0]   ReqData,
  output logic [NREQ-1:0]         ReqReady,
  input  logic                    LoadReq,
  input  logic [WIDTH-1:0]        LoadVal,
  output logic [WIDTH-1:0]        Q,
  output logic [$clog2(NREQ)-1:0] GrantIdx,
  output logic                    Locked
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [WIDTH-1:0] r_q;
  logic [IW-1:0] r_grant_idx;
  logic          r_locked;

  logic [NREQ-1:0] w_pick_grant;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  logic            w_wr_en;
  logic [IW-1:0]   w_wr_idx;
  logic [WIDTH-1:0] w_wr_data;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (ReqValid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Next-state and handshake decode; a load freezes all arbitration state.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_owner;
    ReqReady    = '0;
    if (!LoadReq) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            ReqReady  = w_pick_grant;
            w_wr_en   = 1'b1;
            w_wr_idx  = w_pick_idx;
            w_ptr_nxt = IW'(rr_next(32'(w_pick_idx), NREQ));
            if (ReqLock[w_pick_idx]) begin
              w_state_nxt = ST_LOCKED;
              w_owner_nxt = w_pick_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (ReqValid[r_owner]) begin
            ReqReady[r_owner] = 1'b1;
            w_wr_en           = 1'b1;
            if (!ReqLock[r_owner]) begin
              w_state_nxt = ST_IDLE;
              w_ptr_nxt   = IW'(rr_next(32'(r_owner), NREQ));
            end
          end else if (!ReqLock[r_owner]) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Write-data mux for the accepted requester.
  always_comb begin
    w_wr_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_wr_idx == IW'(i)) w_wr_data = ReqData[i*WIDTH +: WIDTH];
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_locked <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Shared register with load > requester-write priority, plus grant index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q         <= '0;
      r_grant_idx <= '0;
    end else if (LoadReq) begin
      r_q <= LoadVal;
    end else if (w_wr_en) begin
      r_q         <= w_wr_data;
      r_grant_idx <= w_wr_idx;
    end
  end

  assign Q        = r_q;
  assign GrantIdx = r_grant_idx;
  assign Locked   = r_locked;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4, WIDTH=8).
module tb_shared_reg_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       ReqValid;
  logic [NREQ-1:0]       ReqLock;
  logic [NREQ*WIDTH-1:0] ReqData;
  logic [NREQ-1:0]       ReqReady;
  logic                  LoadReq;
  logic [WIDTH-1:0]      LoadVal;
  logic [WIDTH-1:0]      Q;
  logic [1:0]            GrantIdx;
  logic                  Locked;

  int checks = 0;
  int errors = 0;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ReqValid (ReqValid),
    .ReqLock  (ReqLock),
    .ReqData  (ReqData),
    .ReqReady (ReqReady),
    .LoadReq  (LoadReq),
    .LoadVal  (LoadVal),
    .Q        (Q),
    .GrantIdx (GrantIdx),
    .Locked   (Locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    ReqData[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ReqValid = '0; ReqLock = '0; LoadReq = 1'b0; LoadVal = '0;
    ReqData = {8'h44, 8'h33, 8'h22, 8'h11};
    #12;
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", Q); end
    checks++; if (GrantIdx !== 2'd0) begin errors++; $display("FAIL reset_grantidx got %0d exp 0", GrantIdx); end
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", Locked); end
    checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", ReqReady); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    logic [7:0] exp_q;
    int e;
    ReqValid = 4'b1111; ReqLock = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      e = k % 4;
      exp_q = 8'(8'h11 * (e + 1));
      #1;
      checks++; if (ReqReady !== 4'(1 << e)) begin errors++; $display("FAIL fair_ready[%0d] got %b exp %b", k, ReqReady, 4'(1 << e)); end
      tick();
      checks++; if (GrantIdx !== 2'(e)) begin errors++; $display("FAIL fair_grant[%0d] got %0d exp %0d", k, GrantIdx, e); end
      checks++; if (Q !== exp_q) begin errors++; $display("FAIL fair_q[%0d] got %h exp %h", k, Q, exp_q); end
    end
    ReqValid = '0;
  endtask

  task automatic test_load_preempt();
    ReqValid = 4'b0010; LoadReq = 1'b1; LoadVal = 8'hA5;
    #1;
    checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL load_ready got %b exp 0000", ReqReady); end
    tick();
    LoadReq = 1'b0;
    checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL load_q got %h exp a5", Q); end
    checks++; if (GrantIdx !== 2'd3) begin errors++; $display("FAIL load_grantidx got %0d exp 3", GrantIdx); end
    #1;
    checks++; if (ReqReady !== 4'b0010) begin errors++; $display("FAIL load_retry_ready got %b exp 0010", ReqReady); end
    tick();
    checks++; if (Q !== 8'h22) begin errors++; $display("FAIL load_retry_q got %h exp 22", Q); end
    checks++; if (GrantIdx !== 2'd1) begin errors++; $display("FAIL load_retry_grant got %0d exp 1", GrantIdx); end
    ReqValid = '0;
  endtask

  task automatic test_lock_burst();
    logic [7:0] vals [3];
    logic [3:0] lk [3];
    vals[0] = 8'h31; vals[1] = 8'h32; vals[2] = 8'h3F;
    lk[0] = 4'b0100; lk[1] = 4'b0100; lk[2] = 4'b0000;
    ReqValid = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      set_data(2, vals[k]); ReqLock = lk[k];
      #1;
      checks++; if (ReqReady !== 4'b0100) begin errors++; $display("FAIL burst_ready[%0d] got %b exp 0100", k, ReqReady); end
      tick();
      checks++; if (Q !== vals[k]) begin errors++; $display("FAIL burst_q[%0d] got %h exp %h", k, Q, vals[k]); end
      checks++; if (Locked !== (k < 2)) begin errors++; $display("FAIL burst_locked[%0d] got %b exp %b", k, Locked, (k < 2)); end
    end
    ReqLock = '0;
    #1;
    checks++; if (ReqReady !== 4'b1000) begin errors++; $display("FAIL burst_next_ready got %b exp 1000", ReqReady); end
    tick();
    checks++; if (GrantIdx !== 2'd3) begin errors++; $display("FAIL burst_next_grant got %0d exp 3", GrantIdx); end
    checks++; if (Q !== 8'h44) begin errors++; $display("FAIL burst_next_q got %h exp 44", Q); end
    ReqValid = '0;
    set_data(2, 8'h33);
  endtask

  task automatic test_lock_abandon();
    // Ptr is 0 here; requester 1 is the only one valid and locks.
    ReqValid = 4'b0010; ReqLock = 4'b0010;
    tick();
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL abandon_lock got %b exp 1", Locked); end
    checks++; if (Q !== 8'h22) begin errors++; $display("FAIL abandon_first_q got %h exp 22", Q); end
    // Owner idle but still locking: others blocked; a load lands and the lock survives.
    ReqValid = 4'b0100; ReqLock = 4'b0010; LoadReq = 1'b1; LoadVal = 8'h5A;
    tick();
    LoadReq = 1'b0;
    checks++; if (Q !== 8'h5A) begin errors++; $display("FAIL abandon_load_q got %h exp 5a", Q); end
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL abandon_load_locked got %b exp 1", Locked); end
    #1;
    checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL abandon_hold_ready got %b exp 0000", ReqReady); end
    tick();
    checks++; if (Q !== 8'h5A) begin errors++; $display("FAIL abandon_hold_q got %h exp 5a", Q); end
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL abandon_hold_locked got %b exp 1", Locked); end
    // Owner drops lock without data: release with no write.
    ReqLock = 4'b0000;
    #1;
    checks++; if (ReqReady !== 4'b0000) begin errors++; $display("FAIL abandon_drop_ready got %b exp 0000", ReqReady); end
    tick();
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL abandon_drop_locked got %b exp 0", Locked); end
    checks++; if (Q !== 8'h5A) begin errors++; $display("FAIL abandon_drop_q got %h exp 5a", Q); end
    #1;
    checks++; if (ReqReady !== 4'b0100) begin errors++; $display("FAIL abandon_next_ready got %b exp 0100", ReqReady); end
    tick();
    checks++; if (GrantIdx !== 2'd2) begin errors++; $display("FAIL abandon_next_grant got %0d exp 2", GrantIdx); end
    checks++; if (Q !== 8'h33) begin errors++; $display("FAIL abandon_next_q got %h exp 33", Q); end
    ReqValid = '0;
  endtask

  task automatic test_wrap();
    // Ptr is 3 here.
    ReqValid = 4'b1001;
    #1;
    checks++; if (ReqReady !== 4'b1000) begin errors++; $display("FAIL wrap_ready3 got %b exp 1000", ReqReady); end
    tick();
    checks++; if (Q !== 8'h44) begin errors++; $display("FAIL wrap_q3 got %h exp 44", Q); end
    #1;
    checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL wrap_ready0 got %b exp 0001", ReqReady); end
    tick();
    checks++; if (GrantIdx !== 2'd0) begin errors++; $display("FAIL wrap_grant0 got %0d exp 0", GrantIdx); end
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL wrap_q0 got %h exp 11", Q); end
    ReqValid = 4'b1111;
    #1;
    checks++; if (ReqReady !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1_ready got %b exp 0010", ReqReady); end
    tick();
    ReqValid = '0;
  endtask

  task automatic test_async_reset();
    // Ptr is 2 here; requester 2 locks with 3C.
    set_data(2, 8'h3C);
    ReqValid = 4'b0100; ReqLock = 4'b0100;
    tick();
    checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL areset_pre_q got %h exp 3c", Q); end
    checks++; if (Locked !== 1'b1) begin errors++; $display("FAIL areset_pre_locked got %b exp 1", Locked); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL areset_q got %h exp 00", Q); end
    checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL areset_locked got %b exp 0", Locked); end
    checks++; if (GrantIdx !== 2'd0) begin errors++; $display("FAIL areset_grantidx got %0d exp 0", GrantIdx); end
    ReqValid = '0; ReqLock = '0;
    @(negedge clk);
    reset_n = 1'b1;
    ReqValid = 4'b1111;
    #1;
    checks++; if (ReqReady !== 4'b0001) begin errors++; $display("FAIL areset_first_ready got %b exp 0001", ReqReady); end
    tick();
    checks++; if (GrantIdx !== 2'd0) begin errors++; $display("FAIL areset_first_grant got %0d exp 0", GrantIdx); end
    checks++; if (Q !== 8'h11) begin errors++; $display("FAIL areset_first_q got %h exp 11", Q); end
    ReqValid = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_load_preempt();
    test_lock_burst();
    test_lock_abandon();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
